unified_mem_arbiter: RTL and testbench

- Shares one single-ported unified memory between the fetch stage (instruction port) and the memory stage (data port) of the five-stage RV32 core.
- Accepts at most one transaction at a time and drives the external memory request until the memory acknowledges it.
- Returns the response to the owning port and drops fetch responses made stale by a PC redirect.
- Data accesses have priority; an optional starvation guard guarantees fetch forward progress.

---
 rtl/unified_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one single-ported unified memory between the fetch and data ports of the core.
// Optional fetch starvation guard compiled in with `define ARB_STARVE_GUARD_EN.
module unified_mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_adr,
    input  logic        if_kill,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_adr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_adr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t      state, state_nxt;
    logic        own_d;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        kill_flag;
    logic        guard_trip;
    logic        grant_d, grant_i;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] streak;

    assign guard_trip = (streak == 4'(STARVE_LIMIT));

    // Counts data wins while fetch is waiting; holds at the limit instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak <= '0;
        end else if (grant_i) begin
            streak <= '0;
        end else if (state == S_IDLE && !if_req) begin
            streak <= '0;
        end else if (grant_d && if_req && !guard_trip) begin
            streak <= streak + 4'd1;
        end
    end
`else
    logic [3:0] unused_starve_limit;
    assign unused_starve_limit = 4'(STARVE_LIMIT);
    assign guard_trip          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_i   = 1'b0;
        case (state)
            S_IDLE: begin
                // A killed fetch cannot claim the override, so data still goes ahead.
                if (d_req && !(guard_trip && if_req && !if_kill)) begin
                    grant_d = 1'b1;
                end else if (if_req && !if_kill) begin
                    grant_i = 1'b1;
                end
                if (grant_d || grant_i) state_nxt = S_BUSY;
            end
            S_BUSY: begin
                if (mem_ack) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            own_d      <= 1'b0;
            mem_we     <= 1'b0;
            mem_adr    <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            kill_flag  <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            if (grant_d) begin
                own_d     <= 1'b1;
                mem_we    <= d_we;
                mem_adr   <= d_adr;
                mem_wdata <= d_we ? d_wdata : '0;
                mem_wmask <= d_we ? d_wmask : '0;
            end else if (grant_i) begin
                own_d     <= 1'b0;
                mem_we    <= 1'b0;
                mem_adr   <= if_adr;
                mem_wdata <= '0;
                mem_wmask <= '0;
            end
            if (state == S_BUSY && mem_ack) begin
                resp_valid <= 1'b1;
                resp_data  <= mem_we ? '0 : mem_rdata;
            end
            // The flag lives until the response slot of the killed fetch has gone by.
            if (resp_valid) begin
                kill_flag <= 1'b0;
            end else if (if_kill && state == S_BUSY && !own_d) begin
                kill_flag <= 1'b1;
            end
        end
    end

    assign mem_req   = (state == S_BUSY);
    assign d_gnt     = grant_d;
    assign if_gnt    = grant_i;
    assign d_rvalid  = resp_valid & own_d;
    assign if_rvalid = resp_valid & ~own_d & ~kill_flag & ~if_kill;
    assign d_rdata   = resp_data;
    assign if_rdata  = resp_data;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level model and a behavioural memory.
module tb_unified_mem_arbiter;

    localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_kill = 1'b0;
    logic [31:0] if_adr = '0;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_adr = '0, d_wdata = '0;
    logic [3:0]  d_wmask = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_adr, mem_wdata;
    logic [3:0]  mem_wmask;

    unified_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_adr(if_adr), .if_kill(if_kill), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata), .d_wmask(d_wmask),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural memory, word addressed; unwritten words have an address-derived pattern.
    logic [31:0] mem [bit [29:0]];

    // Transaction-level model: at most one access outstanding, one response slot after it.
    bit          m_busy, m_own_d, m_we, m_killed, m_slot;
    logic [31:0] m_adr, m_wdata, m_exp, m_slot_data;
    logic [3:0]  m_wmask;
    int          m_streak, m_wait, m_lat;
    int          next_lat = 0;   // 0 = random 1..3 cycles of mem_req before ack
    bit          force_ack = 1'b0;

    bit          obs_if_gnt, obs_d_gnt, obs_if_rv, obs_d_rv;
    logic [31:0] obs_if_rdata, obs_d_rdata;
    int          obs_cyc;
    bit          rec_seq = 1'b0;
    bit          seq_q[$];

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {a[15:0] ^ 16'h5A5A, a[31:16]};
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        logic [31:0] w;
        w = rd(a);
        for (int b = 0; b < 4; b++) if (m[b]) w[8*b +: 8] = d[8*b +: 8];
        mem[a[31:2]] = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_own_d = 0; m_killed = 0; m_slot = 0; m_streak = 0; m_wait = 0;
        if_req = 0; d_req = 0; if_kill = 0; mem_ack = 0; force_ack = 0;
    endtask

    // One clock cycle: drive memory, check mid-cycle, advance, update the model.
    task automatic cycle();
        bit trip, eg_d, eg_i, ack, exp_irv, busy_before;
        trip = GUARD && (m_streak == LIMIT);
        eg_d = !m_busy && d_req && !(trip && if_req && !if_kill);
        eg_i = !m_busy && !eg_d && if_req && !if_kill;
        ack  = force_ack || (m_busy && (m_wait + 1 >= m_lat));
        mem_ack   = ack;
        mem_rdata = ack ? rd(mem_adr) : $urandom;
        #4;
        check("if_gnt", 32'(if_gnt), 32'(eg_i));
        check("d_gnt", 32'(d_gnt), 32'(eg_d));
        check("mem_req", 32'(mem_req), 32'(m_busy));
        if (m_busy) begin
            check("mem_adr", mem_adr, m_adr);
            check("mem_we", 32'(mem_we), 32'(m_we));
            check("mem_wmask", 32'(mem_wmask), m_we ? 32'(m_wmask) : 32'd0);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
        exp_irv = m_slot && !m_own_d && !m_killed && !if_kill;
        check("d_rvalid", 32'(d_rvalid), 32'(m_slot && m_own_d));
        check("if_rvalid", 32'(if_rvalid), 32'(exp_irv));
        if (m_slot && m_own_d) check("d_rdata", d_rdata, m_slot_data);
        if (exp_irv) check("if_rdata", if_rdata, m_slot_data);
        obs_if_gnt = if_gnt; obs_d_gnt = d_gnt; obs_if_rv = if_rvalid; obs_d_rv = d_rvalid;
        obs_if_rdata = if_rdata; obs_d_rdata = d_rdata; obs_cyc = cyc;
        if (rec_seq && (if_gnt || d_gnt)) seq_q.push_back(d_gnt);

        @(posedge clk); #1;
        cyc++;
        busy_before = m_busy;
        if (eg_i) m_streak = 0;
        else if (!busy_before && !if_req) m_streak = 0;
        else if (eg_d && if_req && m_streak < LIMIT) m_streak++;
        if (busy_before && !m_own_d && if_kill) m_killed = 1;
        m_slot = 0;
        if (busy_before) begin
            if (ack) begin
                if (m_we) wr(m_adr, m_wdata, m_wmask);
                m_slot = 1;
                m_slot_data = m_we ? 32'd0 : m_exp;
                m_busy = 0;
            end else begin
                m_wait++;
            end
        end
        if (eg_d || eg_i) begin
            m_busy = 1; m_own_d = eg_d; m_we = eg_d && d_we;
            m_adr = eg_d ? d_adr : if_adr;
            m_wdata = d_wdata; m_wmask = d_wmask;
            m_exp = rd(m_adr); m_killed = 0; m_wait = 0;
            m_lat = (next_lat == 0) ? int'($urandom_range(1, 3)) : next_lat;
        end
        if (eg_d) d_req = 0;
        if (eg_i) if_req = 0;
        mem_ack = 0;
        force_ack = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (!m_busy && !m_slot && !if_req && !d_req) return;
            cycle();
        end
        n_checks++; n_fail++;
        $display("FAIL drain_timeout observed=busy required=idle (cycle %0d)", cyc);
    endtask

    // Issues one request and returns grant-to-rvalid latency in cycles, -1 on timeout.
    task automatic xact(input bit is_d, input bit we, input logic [31:0] adr,
                        input logic [31:0] wdata, input logic [3:0] wmask,
                        input int lat, output int latency);
        int g;
        g = -1; latency = -1; next_lat = lat;
        if (is_d) begin
            d_req = 1; d_we = we; d_adr = adr; d_wdata = wdata; d_wmask = wmask;
        end else begin
            if_req = 1; if_adr = adr;
        end
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (g < 0 && (is_d ? obs_d_gnt : obs_if_gnt)) g = obs_cyc;
            if (g >= 0 && (is_d ? obs_d_rv : obs_if_rv)) begin
                latency = obs_cyc - g;
                break;
            end
        end
        next_lat = 0;
    endtask

    task automatic reset_dut();
        rst = 0;
        model_reset();
        #2;
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_gnt", 32'({if_gnt, d_gnt}), 0);
        check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 0);
        check("rst_mem_adr", mem_adr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_wmask", 32'(mem_wmask), 0);
        check("rst_rdata", if_rdata | d_rdata, 0);
        @(posedge clk); #1;
        rst = 1;
    endtask

    initial begin
        int lat;
        int rv_cnt;
        model_reset();
        reset_dut();

        // Fetch with ack on the third mem_req cycle.
        mem[30'h100 >> 2] = 32'h0000_0013;
        xact(1'b0, 1'b0, 32'h100, 32'h0, 4'h0, 3, lat);
        check("fetch_latency", lat, 4);
        check("fetch_rdata", obs_if_rdata, 32'h13);
        drain(); cycle();

        // Simultaneous requests: store wins, fetch granted in the store's rvalid cycle.
        d_req = 1; d_we = 1; d_adr = 32'h2000; d_wdata = 32'hDEADBEEF; d_wmask = 4'b0011;
        if_req = 1; if_adr = 32'h104; next_lat = 2;
        cycle();
        check("store_first", 32'({obs_d_gnt, obs_if_gnt}), 32'b10);
        for (int i = 0; i < 10 && !obs_d_rv; i++) cycle();
        check("store_rvalid", 32'(obs_d_rv), 1);
        check("store_rdata", obs_d_rdata, 0);
        check("fetch_gnt_in_store_rv", 32'(obs_if_gnt), 1);
        next_lat = 0;
        drain();
        xact(1'b1, 1'b0, 32'h2000, 32'h0, 4'h0, 1, lat);
        check("load_after_store", obs_d_rdata, 32'h7A5ABEEF);
        drain(); cycle();

        // Kill pulsed during an outstanding fetch.
        if_req = 1; if_adr = 32'h200; next_lat = 3;
        cycle();
        rv_cnt = 0;
        if_kill = 1; cycle(); if_kill = 0;
        for (int i = 0; i < 5; i++) begin cycle(); rv_cnt += int'(obs_if_rv); end
        check("killed_no_rvalid", rv_cnt, 0);
        xact(1'b0, 1'b0, 32'h204, 32'h0, 4'h0, 1, lat);
        check("fetch_after_kill_latency", lat, 2);
        drain(); cycle();

        // Both ports requesting continuously, zero-wait memory.
        rec_seq = 1; next_lat = 1;
        for (int i = 0; i < 26; i++) begin
            if_req = 1; if_adr = 32'h300 + 32'(4 * i);
            d_req = 1; d_we = 0; d_adr = 32'h2000;
            cycle();
        end
        rec_seq = 0; if_req = 0; d_req = 0; next_lat = 0;
        check("seq_len_ok", 32'(seq_q.size() >= 10), 1);
        for (int i = 0; i < 10 && i < seq_q.size(); i++)
            check($sformatf("grant_seq[%0d]", i), 32'(seq_q[i]),
                  32'(!(GUARD && (i % 5 == 4))));
        drain(); cycle();

        // Reset while BUSY, then a stray ack in IDLE.
        d_req = 1; d_we = 0; d_adr = 32'h2004; next_lat = 3;
        cycle(); cycle();
        next_lat = 0;
        reset_dut();
        rv_cnt = 0;
        force_ack = 1; cycle();
        for (int i = 0; i < 2; i++) begin cycle(); rv_cnt += int'(obs_d_rv | obs_if_rv); end
        check("no_rvalid_after_reset", rv_cnt, 0);

        // Eight alternating fetch/data transactions on a zero-wait memory.
        for (int k = 0; k < 8; k++) begin
            xact(k[0], 1'b0, 32'h400 + 32'(8 * k), 32'h0, 4'h0, 1, lat);
            check($sformatf("alt_latency[%0d]", k), lat, 2);
        end
        drain();

        // Random traffic with random kills and memory latencies.
        for (int i = 0; i < 500; i++) begin
            if (!d_req && $urandom_range(0, 2) == 0) begin
                d_req = 1; d_we = $urandom_range(0, 1) == 1;
                d_adr = 32'h3000 + 32'(4 * $urandom_range(0, 7));
                d_wdata = $urandom; d_wmask = 4'($urandom_range(1, 15));
            end
            if (!if_req && $urandom_range(0, 1) == 0) begin
                if_req = 1; if_adr = 32'h3000 + 32'(4 * $urandom_range(0, 7));
            end
            if_kill = ($urandom_range(0, 9) == 0);
            cycle();
        end
        if_kill = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
